// File: rtl/trng_collector.sv
// trng_collector: drives a ring-oscillator TRNG and skips its start-up samples.
// It debiases the raw bit stream with a von Neumann corrector and packs the
// result into words. Words are offered on a valid/ready port. A repetition-count
// health test on the raw stream latches a sticky fault.
module trng_collector #(
   parameter int WORD_WIDTH    = 32,
   parameter int WARMUP_CYCLES = 64,
   parameter int REP_LIMIT     = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   output logic                  trng_en,
   input  logic                  trng_out,
   output logic [WORD_WIDTH-1:0] rdata,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  health_fail,
   input  logic                  clear_fail
);

   localparam int BW = $clog2(WORD_WIDTH + 1);
   localparam int WW = $clog2(WARMUP_CYCLES + 1);
   localparam int RW = $clog2(REP_LIMIT + 1);

   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);
   localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
   localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);
   localparam logic [RW-1:0] REP_ONE   = RW'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WARMUP  = 3'd1,
      COLLECT = 3'd2,
      FULL    = 3'd3,
      FAIL    = 3'd4
   } state_t;

   state_t                state_reg, state_next;
   logic [WW-1:0]         warm_cnt_reg;
   logic [BW-1:0]         bit_cnt_reg;
   logic [RW-1:0]         rep_cnt_reg;
   logic [WORD_WIDTH-1:0] shift_reg;
   logic [WORD_WIDTH-1:0] rdata_reg;
   logic                  rvalid_reg;
   logic                  health_fail_reg;
   logic                  phase_reg;   // 0: expecting first bit of a pair, 1: second
   logic                  first_reg;   // first bit of the current pair
   logic                  prev_reg;    // previous raw sample, for the repetition test

   logic                  pair_emit;
   logic                  word_done;
   logic                  warm_done;
   logic                  rep_hit;
   logic [RW-1:0]         rep_calc;
   logic [WORD_WIDTH-1:0] shifted;

   // Debias, repetition-count and warmup decisions for the current sample
   always_comb begin
      pair_emit = 1'b0;
      word_done = 1'b0;
      warm_done = 1'b0;
      rep_calc  = REP_ONE;
      rep_hit   = 1'b0;
      shifted   = {shift_reg[WORD_WIDTH-2:0], first_reg};

      // A pair with differing bits emits its first bit: (1,0) -> 1, (0,1) -> 0
      pair_emit = phase_reg && (first_reg != trng_out);
      word_done = pair_emit && (bit_cnt_reg == BIT_LAST);
      warm_done = (warm_cnt_reg == WARM_LAST);

      // A zero count marks the first sample after entering COLLECT
      if (rep_cnt_reg == '0) begin
         rep_calc = REP_ONE;
      end else if (trng_out == prev_reg) begin
         rep_calc = (rep_cnt_reg == REP_MAX) ? REP_MAX : rep_cnt_reg + REP_ONE;
      end else begin
         rep_calc = REP_ONE;
      end
      rep_hit = (rep_calc == REP_MAX);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; dropping enable wins over every other transition
   always_comb begin
      state_next = state_reg;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    state_next = WARMUP;
            WARMUP:  if (warm_done) state_next = COLLECT;
            COLLECT: begin
               // A completing pair has differing bits, so it can never also be a fault
               if (rep_hit) begin
                  state_next = FAIL;
               end else if (word_done) begin
                  state_next = FULL;
               end
            end
            FULL:    if (rvalid_reg && rready) state_next = COLLECT;
            FAIL:    if (clear_fail) state_next = WARMUP;
            default: state_next = IDLE;
         endcase
      end
   end

   // Sticky health fault: set by the repetition test, cleared by clear_fail
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         health_fail_reg <= 1'b0;
      end else if (enable && (state_reg == COLLECT) && rep_hit) begin
         health_fail_reg <= 1'b1;
      end else if (clear_fail) begin
         health_fail_reg <= 1'b0;
      end
   end

   // Counters, pair phase, word assembly and the output word register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         warm_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         rep_cnt_reg  <= '0;
         shift_reg    <= '0;
         rdata_reg    <= '0;
         rvalid_reg   <= 1'b0;
         phase_reg    <= 1'b0;
         first_reg    <= 1'b0;
         prev_reg     <= 1'b0;
      end else if (!enable) begin
         // Leaving for IDLE: drop any unaccepted word and all partial progress
         warm_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         rep_cnt_reg  <= '0;
         shift_reg    <= '0;
         rvalid_reg   <= 1'b0;
         phase_reg    <= 1'b0;
         first_reg    <= 1'b0;
         prev_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               warm_cnt_reg <= '0;
            end
            WARMUP: begin
               // Samples are ignored; collection state is held clear for COLLECT entry
               warm_cnt_reg <= warm_done ? '0 : warm_cnt_reg + WW'(1);
               bit_cnt_reg  <= '0;
               rep_cnt_reg  <= '0;
               shift_reg    <= '0;
               phase_reg    <= 1'b0;
            end
            COLLECT: begin
               prev_reg    <= trng_out;
               rep_cnt_reg <= rep_calc;
               if (rep_hit) begin
                  shift_reg   <= '0;
                  bit_cnt_reg <= '0;
                  phase_reg   <= 1'b0;
               end else begin
                  phase_reg <= ~phase_reg;
                  if (!phase_reg) begin
                     first_reg <= trng_out;
                  end else if (pair_emit) begin
                     shift_reg   <= shifted;
                     bit_cnt_reg <= bit_cnt_reg + BW'(1);
                     if (word_done) begin
                        rdata_reg  <= shifted;
                        rvalid_reg <= 1'b1;
                     end
                  end
               end
            end
            FULL: begin
               // Raw bits are ignored; the repetition count restarts on return to COLLECT
               phase_reg   <= 1'b0;
               rep_cnt_reg <= '0;
               if (rvalid_reg && rready) begin
                  rvalid_reg  <= 1'b0;
                  bit_cnt_reg <= '0;
                  shift_reg   <= '0;
               end
            end
            FAIL: begin
               rvalid_reg   <= 1'b0;
               warm_cnt_reg <= '0;
            end
            default: begin
               rvalid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign trng_en     = (state_reg != IDLE);
   assign rdata       = rdata_reg;
   assign rvalid      = rvalid_reg;
   assign health_fail = health_fail_reg;

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: directed test of trng_collector. Expected words are queued
// as stimulus is built, and each word the DUT raises is popped and compared.
module tb_trng_collector;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        trng_en;
   logic        trng_out;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic        health_fail;
   logic        clear_fail;

   int          n_checks;
   int          n_fail;
   int          rise_at;
   int          fail_at;
   logic        stim[$];
   logic [31:0] exp_q[$];
   logic [31:0] word;
   logic        a;

   trng_collector #(
      .WORD_WIDTH   (32),
      .WARMUP_CYCLES(64),
      .REP_LIMIT    (32)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .trng_en    (trng_en),
      .trng_out   (trng_out),
      .rdata      (rdata),
      .rvalid     (rvalid),
      .rready     (rready),
      .health_fail(health_fail),
      .clear_fail (clear_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Run-time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Plays the queued raw bits, one per cycle; records the sample index at which
   // rvalid and health_fail rise, and checks each raised word against the scoreboard
   task automatic play();
      logic prev_v;
      logic prev_f;
      rise_at = -1;
      fail_at = -1;
      prev_v  = rvalid;
      prev_f  = health_fail;
      for (int k = 0; k < stim.size(); k++) begin
         trng_out = stim[k];
         step();
         if (rvalid && !prev_v && rise_at < 0) begin
            rise_at = k + 1;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rdata", rdata, exp_q.pop_front());
         end
         if (health_fail && !prev_f && fail_at < 0) fail_at = k + 1;
         prev_v = rvalid;
         prev_f = health_fail;
      end
      stim.delete();
      $display("transaction: word_at=%0d fault_at=%0d rdata=0x%08h", rise_at, fail_at, rdata);
   endtask

   task automatic accept();
      rready = 1'b1;
      step();
      rready = 1'b0;
      check("rvalid_after_accept", 32'(rvalid), 32'd0);
   endtask

   task automatic push_bits(input logic bit_val, input int n);
      for (int i = 0; i < n; i++) stim.push_back(bit_val);
   endtask

   task automatic push_pair(input logic first_bit, input logic second_bit);
      stim.push_back(first_bit);
      stim.push_back(second_bit);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      enable     = 1'b1;
      rready     = 1'b1;
      trng_out   = 1'b0;
      clear_fail = 1'b0;

      // Reset held with enable and rready asserted
      for (int i = 0; i < 4; i++) begin
         step();
         check("reset_trng_en", 32'(trng_en), 32'd0);
         check("reset_rvalid", 32'(rvalid), 32'd0);
         check("reset_rdata", rdata, 32'd0);
         check("reset_health", 32'(health_fail), 32'd0);
      end
      rready  = 1'b0;
      reset_n = 1'b1;
      step();
      check("release_trng_en", 32'(trng_en), 32'd1);

      // Warmup discard: 64 ones ignored, then (1,0) pairs
      push_bits(1'b1, 64);
      for (int i = 0; i < 32; i++) push_pair(1'b1, 1'b0);
      exp_q.push_back(32'hFFFF_FFFF);
      play();
      check("warmup_word_at", 32'(rise_at), 32'd128);
      check("warmup_no_fault", 32'(fail_at), 32'hFFFF_FFFF);
      check("warmup_health", 32'(health_fail), 32'd0);

      // Backpressure: word held while random bits arrive
      for (int i = 0; i < 100; i++) begin
         trng_out = 1'($urandom_range(0, 1));
         step();
         check("bp_rdata_hold", rdata, 32'hFFFF_FFFF);
         check("bp_rvalid_hold", 32'(rvalid), 32'd1);
      end
      accept();

      // Debias: alternating emitting pairs with discarded (1,1)/(0,0) pairs between
      for (int i = 0; i < 32; i++) begin
         if (i % 2 == 0) push_pair(1'b1, 1'b0);
         else            push_pair(1'b0, 1'b1);
         if (i % 4 == 0) push_pair(1'b1, 1'b1);
         if (i % 4 == 2) push_pair(1'b0, 1'b0);
      end
      exp_q.push_back(32'hAAAA_AAAA);
      play();
      check("debias_word_at", 32'(rise_at), 32'd96);
      check("debias_no_fault", 32'(fail_at), 32'hFFFF_FFFF);
      accept();

      // Health fault: 31 ones, a zero, then 32 ones
      push_bits(1'b1, 31);
      push_bits(1'b0, 1);
      push_bits(1'b1, 32);
      play();
      check("fault_at", 32'(fail_at), 32'd64);
      check("fault_no_word", 32'(rise_at), 32'hFFFF_FFFF);
      check("fault_trng_en", 32'(trng_en), 32'd1);
      for (int i = 0; i < 5; i++) begin
         trng_out = 1'($urandom_range(0, 1));
         step();
         check("fault_sticky", 32'(health_fail), 32'd1);
         check("fault_rvalid", 32'(rvalid), 32'd0);
      end
      clear_fail = 1'b1;
      step();
      clear_fail = 1'b0;
      check("clear_health", 32'(health_fail), 32'd0);
      check("clear_trng_en", 32'(trng_en), 32'd1);

      // Word after recovery: full warmup then random differing pairs
      push_bits(1'b1, 64);
      word = 32'd0;
      for (int i = 0; i < 32; i++) begin
         a = 1'($urandom_range(0, 1));
         push_pair(a, ~a);
         word = {word[30:0], a};
      end
      exp_q.push_back(word);
      play();
      check("recover_word_at", 32'(rise_at), 32'd128);
      accept();

      // Disable mid-word after 10 emitted zeros
      for (int i = 0; i < 10; i++) push_pair(1'b0, 1'b1);
      play();
      check("partial_no_word", 32'(rise_at), 32'hFFFF_FFFF);
      enable = 1'b0;
      step();
      check("disable_trng_en", 32'(trng_en), 32'd0);
      check("disable_rvalid", 32'(rvalid), 32'd0);
      enable = 1'b1;
      step();
      check("reenable_trng_en", 32'(trng_en), 32'd1);
      push_bits(1'b1, 64);
      for (int i = 0; i < 32; i++) push_pair(1'b1, 1'b0);
      exp_q.push_back(32'hFFFF_FFFF);
      play();
      check("reenable_word_at", 32'(rise_at), 32'd128);

      // Reset with a word pending
      reset_n = 1'b0;
      step();
      check("midreset_rvalid", 32'(rvalid), 32'd0);
      check("midreset_rdata", rdata, 32'd0);
      check("midreset_trng_en", 32'(trng_en), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
